// File: rtl/prvp_spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// prvp_spi_arb_pkg
// Shared types and helpers for the SPI-slave transmit arbiter.
//   arb_state_e : arbiter FSM states (idle / locked onto one requester)
//   idw(n)      : width of a requester index, never narrower than one bit
// ---------------------------------------------------------------------------
package prvp_spi_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

    // Index width for n requesters; a single-bit id is kept even for tiny n
    function automatic int idw(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prvp_rr_pick.sv
// ---------------------------------------------------------------------------
// prvp_rr_pick
// Combinational round-robin picker: returns the first set request at or
// after ptr_i, wrapping from N-1 back to 0.
// Ports:
//   req_i [N]   request vector
//   ptr_i [IDW] starting position (highest priority this round)
//   idx_o [IDW] index of the chosen request (0 when none)
//   any_o       at least one request is set
// ---------------------------------------------------------------------------
module prvp_rr_pick
    import prvp_spi_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idw(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    // Walk the offsets from farthest to nearest so that the request closest
    // to the pointer is the one left standing after the loop.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] cand;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (IDW + 1)'(k);
            if (sum >= (IDW + 1)'(N)) begin
                sum = sum - (IDW + 1)'(N);
            end
            cand = sum[IDW-1:0];
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prvp_spi_slave_tx_arbiter.sv
// ---------------------------------------------------------------------------
// prvp_spi_slave_tx_arbiter
// Round-robin, packet-locking arbiter that shares the write port of the
// SPI-slave dual-clock FIFO among NUM_REQ producers. A grant is held until
// the granted requester sends its last beat or MAX_BEATS beats have gone
// through (0 = no cap). Runs entirely in the FIFO write clock domain.
//
// Optional build macro:
//   PRVP_SPI_ARB_OUT_REG_EN - registers the output through a 2-entry skid
//                             buffer (1 cycle latency, full throughput).
//
// Ports:
//   clk, rst             FIFO write clock, async active-high reset
//   req_data/valid/last  per-requester beat, slice i = requester i
//   req_ready            per-requester ready, only the granted bit can be 1
//   out_data/valid/last  beat towards the FIFO write side
//   out_ready            FIFO can accept a beat
//   out_id               index of the granted requester
//   busy                 arbiter is locked onto a requester
// ---------------------------------------------------------------------------
module prvp_spi_slave_tx_arbiter
    import prvp_spi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [idw(NUM_REQ)-1:0]       out_id,
    output logic                          busy
);

    localparam int IDW  = idw(NUM_REQ);
    localparam int CNTW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNTW-1:0] CAP_LAST = (MAX_BEATS > 0) ? CNTW'(MAX_BEATS - 1) : '0;
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NUM_REQ - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rrPtr_q, rrPtr_d;
    logic [CNTW-1:0] beatCnt_q, beatCnt_d;

    logic [IDW-1:0] pickIdx;
    logic           pickAny;

    logic [DATA_WIDTH-1:0] reqDataArr [NUM_REQ];
    logic [DATA_WIDTH-1:0] grantData;
    logic                  grantValid;
    logic                  capHit;
    logic                  lockLast;
    logic                  sinkReady;
    logic                  acceptBeat;

    // Unpack the flat data bus so the granted slice can be picked by index
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign reqDataArr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    prvp_rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rrPtr_q),
        .idx_o (pickIdx),
        .any_o (pickAny)
    );

    assign grantData  = reqDataArr[grant_q];
    assign grantValid = req_valid[grant_q];
    // The fairness cap fires on the beat that would be the MAX_BEATS-th
    assign capHit     = (MAX_BEATS != 0) && (beatCnt_q == CAP_LAST);
    assign lockLast   = req_last[grant_q] | capHit;
    // A beat is taken from the granted requester whenever the sink side can
    // take it; all FSM bookkeeping is driven from this input-side handshake.
    assign acceptBeat = (state_q == ARB_LOCK) && grantValid && sinkReady;
    assign busy       = (state_q == ARB_LOCK);

    // State register and arbitration bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            rrPtr_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rrPtr_q   <= rrPtr_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    // Next-state logic: idle picks the next requester (one bubble cycle),
    // lock counts beats and releases on the last beat of the grant.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rrPtr_d   = rrPtr_q;
        beatCnt_d = beatCnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pickAny) begin
                    grant_d = pickIdx;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (acceptBeat) begin
                    if (lockLast) begin
                        state_d   = ARB_IDLE;
                        beatCnt_d = '0;
                        rrPtr_d   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Only the granted requester ever sees ready
    always_comb begin
        req_ready = '0;
        if (state_q == ARB_LOCK) begin
            req_ready[grant_q] = sinkReady;
        end
    end

`ifdef PRVP_SPI_ARB_OUT_REG_EN

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [IDW-1:0]        id;
    } skid_t;

    skid_t       skidMem_q [2];
    skid_t       skidIn;
    skid_t       skidHead;
    logic        skidWr_q;
    logic        skidRd_q;
    logic [1:0]  skidCnt_q, skidCnt_d;
    logic        skidPush;
    logic        skidPop;

    assign sinkReady = (skidCnt_q != 2'd2);
    assign skidPush  = acceptBeat;
    assign skidPop   = (skidCnt_q != 2'd0) && out_ready;
    assign skidHead  = skidMem_q[skidRd_q];

    always_comb begin
        skidIn      = '0;
        skidIn.data = grantData;
        skidIn.last = lockLast;
        skidIn.id   = grant_q;
    end

    // Occupancy moves by at most one per cycle since push and pop can coincide
    always_comb begin
        skidCnt_d = skidCnt_q;
        unique case ({skidPush, skidPop})
            2'b10:   skidCnt_d = skidCnt_q + 2'd1;
            2'b01:   skidCnt_d = skidCnt_q - 2'd1;
            default: skidCnt_d = skidCnt_q;
        endcase
    end

    // Two-entry ring: the second slot absorbs the beat accepted in the same
    // cycle the FIFO stalls, so ready can be a pure register-derived signal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                skidMem_q[i] <= '0;
            end
            skidWr_q  <= 1'b0;
            skidRd_q  <= 1'b0;
            skidCnt_q <= 2'd0;
        end else begin
            if (skidPush) begin
                skidMem_q[skidWr_q] <= skidIn;
                skidWr_q            <= ~skidWr_q;
            end
            if (skidPop) begin
                skidRd_q <= ~skidRd_q;
            end
            skidCnt_q <= skidCnt_d;
        end
    end

    // Outputs are zeroed while the buffer is empty so stale entries never leak
    always_comb begin
        out_valid = (skidCnt_q != 2'd0);
        out_data  = '0;
        out_last  = 1'b0;
        out_id    = '0;
        if (out_valid) begin
            out_data = skidHead.data;
            out_last = skidHead.last;
            out_id   = skidHead.id;
        end
    end

`else

    assign sinkReady = out_ready;

    // Zero-latency path straight from the granted requester
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_id    = '0;
        if (state_q == ARB_LOCK) begin
            out_data  = grantData;
            out_valid = grantValid;
            out_last  = lockLast;
            out_id    = grant_q;
        end
    end

`endif

endmodule
